// File: rtl/ext_pipe_pkg.sv
// ext_pipe_pkg: shared encodings for the immediate / load-data extender.
//   EOP_W  : width of the operation select
//   eop_e  : operation encodings (immediate modes and load extension modes)
package ext_pipe_pkg;

  localparam int EOP_W = 3;

  typedef enum logic [EOP_W-1:0] {
    EXT_SIGN = 3'b000,  // sign-extend imm
    EXT_ZERO = 3'b001,  // zero-extend imm
    EXT_LUI  = 3'b010,  // imm in the top bits, low bits zero
    EXT_BR   = 3'b011,  // sign-extend imm, shift left by SHIFT
    EXT_LB   = 3'b100,  // load byte, signed
    EXT_LBU  = 3'b101,  // load byte, unsigned
    EXT_LH   = 3'b110,  // load halfword, signed
    EXT_LHU  = 3'b111   // load halfword, unsigned
  } eop_e;

endpackage

// File: rtl/ext_core.sv
// ext_core: purely combinational mode mux of the extender.
//   eop      in  : operation select (eop_e encodings)
//   imm      in  : immediate operand, IN_W bits
//   word     in  : loaded data word (load modes)
//   offset   in  : byte address bits [1:0] (load modes)
//   ext      out : extended result, OUT_W bits
//   misalign out : halfword mode with an odd byte offset
module ext_core
  import ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic [EOP_W-1:0] eop,
  input  logic [IN_W-1:0]  imm,
  input  logic [31:0]      word,
  input  logic [1:0]       offset,
  output logic [OUT_W-1:0] ext,
  output logic             misalign
);

  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [OUT_W-1:0] imm_sext;
  logic [OUT_W-1:0] imm_zext;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  // Halfword lane comes from offset[1] only; an odd offset is flagged, not corrected.
  assign half_sel = word[{offset[1], 4'b0000} +: 16];
  assign imm_sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign imm_zext = {{(OUT_W-IN_W){1'b0}}, imm};

  always_comb begin
    ext      = imm_sext;
    misalign = 1'b0;
    case (eop)
      EXT_SIGN: ext = imm_sext;
      EXT_ZERO: ext = imm_zext;
      EXT_LUI:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
      EXT_BR:   ext = imm_sext << SHIFT;
      EXT_LB:   ext = {{(OUT_W-8){byte_sel[7]}}, byte_sel};
      EXT_LBU:  ext = {{(OUT_W-8){1'b0}}, byte_sel};
      EXT_LH: begin
        ext      = {{(OUT_W-16){half_sel[15]}}, half_sel};
        misalign = offset[0];
      end
      EXT_LHU: begin
        ext      = {{(OUT_W-16){1'b0}}, half_sel};
        misalign = offset[0];
      end
      default: ext = imm_sext;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-data extender with a 2-entry skid FIFO.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (in_ready is registered)
//   eop, imm, word, offset : request operands
//   flush               : synchronous, dominant discard of all buffered results
//   out_valid / out_ready : result handshake
//   ext, misalign       : head-of-FIFO result and sideband
module ext_pipe
  import ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EOP_W-1:0] eop,
  input  logic [IN_W-1:0]  imm,
  input  logic [31:0]      word,
  input  logic [1:0]       offset,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] ext,
  output logic             misalign
);

  if (OUT_W < 2*IN_W || OUT_W < 32) begin : g_bad_width
    $error("ext_pipe: OUT_W must be >= 2*IN_W and >= 32");
  end

  // Entry layout: {misalign, ext}
  localparam int EW = OUT_W + 1;

  logic [OUT_W-1:0] core_ext;
  logic             core_mis;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_core (
    .eop      (eop),
    .imm      (imm),
    .word     (word),
    .offset   (offset),
    .ext      (core_ext),
    .misalign (core_mis)
  );

  logic [EW-1:0] mem   [2];
  logic [EW-1:0] mem_n [2];
  logic          rptr, wptr, rptr_n, wptr_n;
  logic [1:0]    cnt, cnt_n;
  logic          in_ready_q;
  logic [EW-1:0] head_q;
  logic          push, pop;

  assign in_ready  = in_ready_q;
  assign out_valid = (cnt != 2'd0);
  assign ext       = head_q[OUT_W-1:0];
  assign misalign  = head_q[OUT_W];

  always_comb begin
    push   = in_valid && in_ready_q && !flush;
    pop    = out_valid && out_ready && !flush;
    mem_n  = mem;
    rptr_n = rptr ^ pop;
    wptr_n = wptr ^ push;
    cnt_n  = cnt + {1'b0, push} - {1'b0, pop};
    if (push) mem_n[wptr] = {core_mis, core_ext};
    if (flush) begin
      rptr_n = 1'b0;
      wptr_n = 1'b0;
      cnt_n  = 2'd0;
    end
  end

  // head_q mirrors the next head so ext is a clean register output; it is
  // left alone when the FIFO goes empty so the idle value stays deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      rptr       <= 1'b0;
      wptr       <= 1'b0;
      cnt        <= 2'd0;
      in_ready_q <= 1'b1;
      head_q     <= '0;
    end else begin
      mem[0]     <= mem_n[0];
      mem[1]     <= mem_n[1];
      rptr       <= rptr_n;
      wptr       <= wptr_n;
      cnt        <= cnt_n;
      in_ready_q <= (cnt_n != 2'd2);
      if (cnt_n != 2'd0) head_q <= mem_n[rptr_n];
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;
  import ext_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  eop;
  logic [15:0] imm;
  logic [31:0] word;
  logic [1:0]  offset;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] ext;
  logic        misalign;

  ext_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .eop(eop), .imm(imm), .word(word), .offset(offset), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ext(ext), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic mis; logic [31:0] ext;} exp_t;
  exp_t q[$];
  int nvec = 0;
  int nerr = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: a transfer seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_out: got ext=%h mis=%b expected no output", ext, misalign);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out", {31'b0, misalign, ext}, {31'b0, e.mis, e.ext});
      end
    end
  end

  // Present one request and return at posedge+1 after it is accepted.
  task automatic issue(input logic [2:0] op, input logic [15:0] im, input logic [31:0] w,
                       input logic [1:0] off, input logic [31:0] e, input logic m);
    int t = 0;
    in_valid = 1'b1; eop = op; imm = im; word = w; offset = off;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back({m, e});
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 50) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] W = 32'h80F17F02;

  initial begin
    reset = 1'b1; in_valid = 1'b0; eop = 3'd0; imm = '0; word = '0; offset = '0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_ready", {63'b0, in_ready}, 64'd1);
    chk("reset_ext",   {31'b0, misalign, ext}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Immediate modes, one per cycle
    out_ready = 1'b1;
    issue(EXT_SIGN, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0);
    chk("latency", {63'b0, out_valid}, 64'd1);
    issue(EXT_ZERO, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0);
    issue(EXT_LUI,  16'h8001, 32'h0, 2'd0, 32'h80010000, 1'b0);
    issue(EXT_BR,   16'h8001, 32'h0, 2'd0, 32'hFFFE0004, 1'b0);
    // Load modes
    issue(EXT_LB,   16'h0, W, 2'd2, 32'hFFFFFFF1, 1'b0);
    issue(EXT_LBU,  16'h0, W, 2'd3, 32'h00000080, 1'b0);
    issue(EXT_LH,   16'h0, W, 2'd2, 32'hFFFF80F1, 1'b0);
    issue(EXT_LHU,  16'h0, W, 2'd0, 32'h00007F02, 1'b0);
    issue(EXT_LH,   16'h0, W, 2'd1, 32'h00007F02, 1'b1);
    issue(EXT_LB,   16'h0, W, 2'd1, 32'h0000007F, 1'b0);
    idle();
    drain();

    // Backpressure: two accepted, third stalls until the first pop
    out_ready = 1'b0;
    issue(EXT_ZERO, 16'h1111, 32'h0, 2'd0, 32'h00001111, 1'b0);
    issue(EXT_SIGN, 16'hF222, 32'h0, 2'd0, 32'hFFFFF222, 1'b0);
    in_valid = 1'b1; eop = EXT_LUI; imm = 16'h3333;
    @(negedge clk);
    chk("full_in_ready", {63'b0, in_ready}, 64'd0);
    chk("stall_hold",    {31'b0, misalign, ext}, {31'b0, 1'b0, 32'h00001111});
    @(posedge clk); #1;
    chk("stall_hold2",   {31'b0, misalign, ext}, {31'b0, 1'b0, 32'h00001111});
    out_ready = 1'b1;
    issue(EXT_LUI, 16'h3333, 32'h0, 2'd0, 32'h33330000, 1'b0);
    idle();
    drain();

    // Streaming push+pop at count=1
    for (int i = 0; i < 10; i++) begin
      issue(EXT_ZERO, 16'h0100 + 16'(i), 32'h0, 2'd0, 32'h00000100 + i, 1'b0);
      chk("stream_valid", {63'b0, out_valid}, 64'd1);
      chk("stream_ready", {63'b0, in_ready}, 64'd1);
    end
    idle();
    drain();

    // Flush at count=2 with a same-cycle push and pop
    out_ready = 1'b0;
    issue(EXT_ZERO, 16'hDEAD, 32'h0, 2'd0, 32'h0000DEAD, 1'b0);
    issue(EXT_ZERO, 16'hBEEF, 32'h0, 2'd0, 32'h0000BEEF, 1'b0);
    in_valid = 1'b1; imm = 16'hCAFE; out_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    q.delete();
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_ready", {63'b0, in_ready}, 64'd1);
    repeat (4) @(posedge clk);
    #1;
    issue(EXT_SIGN, 16'h7FFF, 32'h0, 2'd0, 32'h00007FFF, 1'b0);
    idle();
    drain();

    // Async reset mid-cycle with count=2
    out_ready = 1'b0;
    issue(EXT_ZERO, 16'hAAAA, 32'h0, 2'd0, 32'h0000AAAA, 1'b0);
    issue(EXT_LH,   16'h0, W, 2'd3, 32'hFFFF80F1, 1'b1);
    idle();
    @(negedge clk);
    chk("pre_reset_valid", {63'b0, out_valid}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid", {63'b0, out_valid}, 64'd0);
    chk("areset_ready", {63'b0, in_ready}, 64'd1);
    chk("areset_ext",   {31'b0, misalign, ext}, 64'd0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    issue(EXT_BR, 16'h0001, 32'h0, 2'd0, 32'h00000004, 1'b0);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender.
- Adds load-data byte/halfword extension modes, misalignment flagging and a valid/ready handshake.
- Output is buffered through a 2-entry skid buffer.
- Sits between decode/MEM-stage operand selection and the consuming stage. Breaks the combinational path and absorbs one cycle of downstream stall without bubbles.

Parameters:
- IN_W, 16: immediate width.
- OUT_W, 32: result width. Elaboration error if OUT_W < 2*IN_W or OUT_W < 32.
- SHIFT, 2: left shift applied in branch-offset mode.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted when in_valid && in_ready.
- eop  input  3  operation select.
- imm  input  IN_W  immediate operand.
- word  input  32  loaded data word (load modes).
- offset  input  2  byte address bits [1:0] (load modes).
- flush  input  1  discard all buffered results.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- ext  output  OUT_W  extended result.
- misalign  output  1  sideband: result came from a halfword mode with offset[0]=1.

Behaviour:
- Modes (eop):
  - 000: sign-extend imm to OUT_W.
  - 001: zero-extend imm.
  - 010: imm placed in bits [OUT_W-1 : OUT_W-IN_W], lower bits zero.
  - 011: sign-extend imm, then shift left by SHIFT; upper bits lost, result OUT_W wide.
  - 100: lb. Byte = word[8*offset +: 8], sign-extended.
  - 101: lbu. Same byte, zero-extended.
  - 110: lh. Half = word[16*offset[1] +: 16], sign-extended.
  - 111: lhu. Same half, zero-extended.
- Misalign: in modes 110/111 with offset[0]=1, misalign=1 travels with the entry and the result still uses offset[1]. All other modes give misalign=0.
- Computation: combinational on the accepted inputs; the result is captured at the accept edge. Latency is 1 cycle: accepted at edge N, out_valid=1 after edge N at the earliest.
- Buffer:
  - 2-entry FIFO of {ext, misalign}, count 0..2.
  - in_ready = (count < 2), driven from a register, with no combinational path from out_ready.
  - out_valid = (count > 0). Head entry drives ext/misalign.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged, and the head advances while the new entry is written.
  - Full (count=2): in_ready=0, so a push is impossible. A pop in that cycle frees a slot next cycle.
  - Empty: out_valid=0, and out_ready is ignored.
- Ordering: strict FIFO, with wrap-around of the 1-bit read/write pointers.
- Output stability: while out_valid && !out_ready, ext and misalign must hold stable.
- Flush: synchronous and dominant. At the edge, count=0, pointers=0, and any same-cycle push or pop is discarded. in_ready=1 the next cycle.
- Reset (asynchronous, any time including mid-transfer):
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - ext=0, misalign=0; storage entries cleared to 0.
  - Release is synchronised to clk by the surrounding design.
- When out_valid=0, ext holds the last head value (0 after reset). This value is don't-care for consumers but deterministic.

Decomposition:
- Shared package holds:
  - EOp encodings: EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_BR, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU.
  - Width of eop (3).
- One natural sub-module: ext_core, the purely combinational mode mux (imm/word/offset/eop to ext/misalign), parametrised by IN_W/OUT_W/SHIFT. ext_pipe instantiates it plus the skid FIFO.

Test Plan:
- Modes, out_ready=1, one request per cycle:
  - imm=16'h8001, eop=000 → ext=32'hFFFF8001.
  - eop=001 → 32'h00008001.
  - eop=010 → 32'h80010000.
  - eop=011 → 32'hFFFE0004.
  - Each result arrives 1 cycle after accept.
- Load modes, word=32'h80F17F02:
  - lb offset=2 → 32'hFFFFFFF1.
  - lbu offset=3 → 32'h00000080.
  - lh offset=2 → 32'hFFFF80F1.
  - lhu offset=0 → 32'h00007F02.
  - lh offset=1 → misalign=1 with ext=32'h00007F02.
- Backpressure: out_ready=0, issue 3 back-to-back requests.
  - First two accepted; in_ready=0 on the third.
  - Raise out_ready: results drain in order, the third is accepted after the first pop, no loss or duplication.
- Simultaneous push/pop at count=1 for 10 cycles: count stays 1, out_valid constant 1, outputs match input sequence delayed by 1.
- Flush with count=2 and a same-cycle push:
  - Next cycle out_valid=0, in_ready=1.
  - Flushed values never appear.
- Async reset asserted mid-cycle with count=2: out_valid=0, ext=0, in_ready=1 immediately, without waiting for a clock edge.
